imm_ext_pipe: RTL and testbench

Registered, parametrised successor to the decode-stage immediate extender. It zero- or sign-extends one of three immediate fields of an instruction word to `DATA_W` bits and presents the result through a valid/ready stage with a two-entry skid buffer. Error is flagged from the select encoding, not from the output value, so a legitimate immediate equal to `BAD_VALUE` is never flagged. A saturating error counter is included. It sits between fetch/decode and the execute-operand mux.

---
 rtl/imm_ext_pkg.sv | 25 ++
 rtl/imm_ext_pipe_if.sv | 27 ++
 rtl/imm_ext_comb.sv | 45 ++++
 rtl/imm_ext_pipe.sv | 129 ++++++++++++
 tb/tb_imm_ext_pipe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate extender: select/op codes, occupancy
// states of the output skid buffer, and the default error value.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    SEL_A   = 2'b00,
    SEL_B   = 2'b01,
    SEL_C   = 2'b10,
    SEL_BAD = 2'b11
  } sel_e;

  typedef enum logic {
    OP_ZEXT = 1'b0,
    OP_SEXT = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  localparam logic [15:0] BAD_VALUE_DEF = 16'hBADD;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Valid/ready bundle between decode (master) and the immediate stage (slave).
interface imm_ext_pipe_if #(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 11
) ();

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic [1:0]         select;
  logic               op;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  imm;
  logic               err;

  modport master (
    output in_valid, instr, select, op, out_ready,
    input  in_ready, out_valid, imm, err
  );

  modport slave (
    input  in_valid, instr, select, op, out_ready,
    output in_ready, out_valid, imm, err
  );

endinterface

// File: rtl/imm_ext_comb.sv
// Combinational immediate extender: picks field A/B/C by select and zero- or
// sign-extends it; select 11 yields BAD_VALUE with err set.
module imm_ext_comb
  import imm_ext_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          INSTR_W   = 11,
  parameter int          FLD_A_W   = 5,
  parameter int          FLD_B_W   = 8,
  parameter int          FLD_C_W   = 11,
  parameter logic [15:0] BAD_VALUE = BAD_VALUE_DEF
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [1:0]         select,
  input  logic               op,
  output logic [DATA_W-1:0]  imm,
  output logic               err
);

  logic signed [FLD_A_W-1:0] fld_a;
  logic signed [FLD_B_W-1:0] fld_b;
  logic signed [FLD_C_W-1:0] fld_c;
  logic                      sext;

  assign fld_a = instr[FLD_A_W-1:0];
  assign fld_b = instr[FLD_B_W-1:0];
  assign fld_c = instr[FLD_C_W-1:0];
  assign sext  = (op == OP_SEXT);

  // Casting a signed field to DATA_W replicates its MSB; $unsigned pads zeros.
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (sel_e'(select))
      SEL_A:   imm = sext ? DATA_W'(fld_a) : DATA_W'($unsigned(fld_a));
      SEL_B:   imm = sext ? DATA_W'(fld_b) : DATA_W'($unsigned(fld_b));
      SEL_C:   imm = sext ? DATA_W'(fld_c) : DATA_W'($unsigned(fld_c));
      default: begin
        imm = DATA_W'(BAD_VALUE);
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: extension on input, two-entry skid buffer
// on output, and a saturating count of delivered errored items.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          INSTR_W   = 11,
  parameter int          FLD_A_W   = 5,
  parameter int          FLD_B_W   = 8,
  parameter int          FLD_C_W   = 11,
  parameter logic [15:0] BAD_VALUE = BAD_VALUE_DEF,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  imm_ext_pipe_if.slave    bus,
  output logic [CNT_W-1:0] err_cnt
);

  logic [DATA_W-1:0] ext_imm;
  logic              ext_err;

  imm_ext_comb #(
    .DATA_W    (DATA_W),
    .INSTR_W   (INSTR_W),
    .FLD_A_W   (FLD_A_W),
    .FLD_B_W   (FLD_B_W),
    .FLD_C_W   (FLD_C_W),
    .BAD_VALUE (BAD_VALUE)
  ) u_comb (
    .instr  (bus.instr),
    .select (bus.select),
    .op     (bus.op),
    .imm    (ext_imm),
    .err    (ext_err)
  );

  occ_e              occ_q, occ_d;
  logic [DATA_W-1:0] main_imm_q, main_imm_d;
  logic              main_err_q, main_err_d;
  logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
  logic              skid_err_q, skid_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic drain;

  // Ready comes straight from occupancy flops; held low while reset is applied.
  assign in_ready  = !rst && (occ_q != ST_FULL);
  assign out_valid = (occ_q != ST_EMPTY);
  assign accept    = bus.in_valid && in_ready;
  assign drain     = out_valid && bus.out_ready;

  always_comb begin
    occ_d      = occ_q;
    main_imm_d = main_imm_q;
    main_err_d = main_err_q;
    skid_imm_d = skid_imm_q;
    skid_err_d = skid_err_q;
    err_cnt_d  = err_cnt_q;

    if (drain && main_err_q && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + CNT_W'(1);

    if (flush) begin
      occ_d = ST_EMPTY;
    end else begin
      case (occ_q)
        ST_EMPTY: begin
          if (accept) begin
            main_imm_d = ext_imm;
            main_err_d = ext_err;
            occ_d      = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_imm_d = ext_imm;
            main_err_d = ext_err;
          end else if (accept) begin
            skid_imm_d = ext_imm;
            skid_err_d = ext_err;
            occ_d      = ST_FULL;
          end else if (drain) begin
            occ_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_imm_d = skid_imm_q;
            main_err_d = skid_err_q;
            occ_d      = ST_ONE;
          end
        end
        default: occ_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= ST_EMPTY;
      main_imm_q <= '0;
      main_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      occ_q      <= occ_d;
      main_imm_q <= main_imm_d;
      main_err_q <= main_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Skid contents are only read when occupancy says FULL, so no reset needed.
  always_ff @(posedge clk) begin
    skid_imm_q <= skid_imm_d;
    skid_err_q <= skid_err_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.imm       = main_imm_q;
  assign bus.err       = main_err_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: accepted inputs push the reference
// result, a negedge monitor pops and compares on every output transfer.
module tb_imm_ext_pipe;

  typedef struct {
    logic [15:0] imm;
    logic        err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] err_cnt;

  imm_ext_pipe_if #(.DATA_W(16), .INSTR_W(11)) bus ();

  imm_ext_pipe dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  exp_t q[$];
  int   mcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: take the low w bits as a number, subtract 2^w if sign-extending a negative field.
  function automatic exp_t model(input logic [10:0] i, input logic [1:0] s, input logic o);
    exp_t        e;
    int          w;
    int unsigned v;
    if (s == 2'b11) begin
      e.imm = 16'hBADD;
      e.err = 1'b1;
      return e;
    end
    w = (s == 2'b00) ? 5 : (s == 2'b01) ? 8 : 11;
    v = int'(i) % (1 << w);
    if (o && v >= (1 << (w - 1))) v = v + 65536 - (1 << w);
    e.imm = v[15:0];
    e.err = 1'b0;
    return e;
  endfunction

  // Monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!rst && q.size() < 2)});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (q.size() != 0)});
    chk("err_cnt", {24'd0, err_cnt}, mcnt);
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("q_underflow", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("imm", {16'd0, bus.imm}, {16'd0, e.imm});
          chk("err", {31'd0, bus.err}, {31'd0, e.err});
          if (e.err && mcnt < 255) mcnt++;
        end
      end
      if (flush) q.delete();
      else if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.instr, bus.select, bus.op));
    end
  end

  task automatic send(input logic [10:0] i, input logic [1:0] s, input logic o);
    bus.in_valid = 1'b1;
    bus.instr    = i;
    bus.select   = s;
    bus.op       = o;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("send_accept", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.select    = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("rst_imm", {16'd0, bus.imm}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Field A sign-extended.
    bus.out_ready = 1'b1;
    send(11'h010, 2'b00, 1'b1);
    @(negedge clk);
    chk("a_sext_vld", {31'd0, bus.out_valid}, 32'd1);
    chk("a_sext_imm", {16'd0, bus.imm}, 32'h0000FFF0);
    @(posedge clk); #1;

    // Back-to-back B zext / C sext.
    send(11'h080, 2'b01, 1'b0);
    send(11'h400, 2'b10, 1'b1);
    @(negedge clk);
    chk("c_sext_imm", {16'd0, bus.imm}, 32'h0000FC00);
    @(posedge clk); #1;
    cycles(2);

    // Stall with three offered items.
    bus.out_ready = 1'b0;
    send(11'h1F, 2'b00, 1'b0);
    send(11'hFF, 2'b01, 1'b1);
    @(negedge clk);
    chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.instr = 11'h5A5; bus.select = 2'b10; bus.op = 1'b1;
    cycles(3);
    bus.out_ready = 1'b1;
    send(11'h5A5, 2'b10, 1'b1);
    cycles(4);

    // Legal C sext must not flag err.
    send(11'h3DD, 2'b10, 1'b1);
    cycles(2);

    // Flush from FULL with a new offer in the same cycle.
    bus.out_ready = 1'b0;
    send(11'h001, 2'b00, 1'b0);
    send(11'h002, 2'b01, 1'b0);
    bus.in_valid = 1'b1; bus.instr = 11'h003; bus.select = 2'b00; bus.op = 1'b0;
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_rdy", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    cycles(3);

    // 300 invalid selects: counter saturates.
    for (int n = 0; n < 300; n++) send(11'($urandom), 2'b11, 1'($urandom));
    cycles(3);
    chk("cnt_sat", {24'd0, err_cnt}, 32'd255);

    // Reset in FULL with err_cnt = 5.
    do_reset();
    for (int n = 0; n < 5; n++) send(11'($urandom), 2'b11, 1'b0);
    cycles(2);
    bus.out_ready = 1'b0;
    send(11'h7FF, 2'b01, 1'b1);
    send(11'h155, 2'b10, 1'b0);
    @(negedge clk);
    chk("cnt_5", {24'd0, err_cnt}, 32'd5);
    @(posedge clk); #1;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_imm", {16'd0, bus.imm}, 32'd0);
    chk("mid_rst_err", {31'd0, bus.err}, 32'd0);
    chk("mid_rst_cnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk); #1;

    // Randomized traffic with occasional flush.
    for (int n = 0; n < 600; n++) begin
      bus.in_valid  = 1'($urandom);
      bus.instr     = 11'($urandom);
      bus.select    = 2'($urandom);
      bus.op        = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 31) == 0);
      cycles(1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    cycles(4);
    @(negedge clk);
    chk("drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
